axi_at86rf215_iq_tx: RTL and testbench
======================================

# axi_at86rf215_iq_tx

AXI-Stream-to-LVDS I/Q serializer for the AT86RF215 transmit path; the transmit counterpart of the `axi_at86rf215_iq_rx` deserializer.
- Accepts 32-bit I/Q sample words on an AXI4-Stream slave port and buffers them in a small FIFO.
- Formats each sample into the transceiver's 32-bit I/Q frame (I_SYNC/Q_SYNC headers) and shifts it out 2 bits per clock, MSB first.
- Pads between samples with all-zero frames according to `sample_rate`, so the `axi_at86rf215_iq_rx` block can lock on the output.

## Interface
- `C_S00_AXIS_TDATA_WIDTH`, 32: stream data width; only 32 is supported.
- `FIFO_DEPTH`, 4: sample FIFO entries; power of two, ≥2.
- `MAX_SAMPLE_RATE`, 10: upper clamp for `sample_rate`.
- `aclk`  in  1  sole clock.
- `aresetn`  in  1  synchronous, active-low reset.
- `s00_axis_tvalid`  in  1  sample valid.
- `s00_axis_tready`  out  1  high when the FIFO is not full.
- `s00_axis_tdata`  in  32  I in [28:16], Q in [12:0], 13-bit two's complement; other bits ignored.
- `s00_axis_tlast`  in  1  ignored.
- `sample_rate`  in  4  frames per sample period; 0 is treated as 1; values above `MAX_SAMPLE_RATE` clamp to it.
- `enable`  in  1  transmit enable.
- `iq_data_out`  out  2  serial dibit to the LVDS driver.
- `tx_active`  out  1  high while in RUN.
- `underflow`  out  1  one-cycle pulse when a data slot finds the FIFO empty.

## Operation
- **Frame format:** {2'b10, I[12:0], 1'b0, 2'b01, Q[12:0], 1'b0}. A zero frame is 32'h0.
- **Counters:**
  - `bit_cnt` runs 0..15; one dibit per cycle, so one frame every 16 cycles.
  - `slot_cnt` runs 0..N-1, where N is the effective sample rate.
  - Slot 0 is the data slot; slots 1..N-1 send zero frames.
  - N is latched at the start of slot 0 and held for the whole sample period. A mid-period change takes effect at the next period.
- **FSM states:**
  - IDLE: `iq_data_out`=0, counters held at 0.
  - RUN: frames are emitted back-to-back.
  - DRAIN: the current frame finishes, then the FSM goes to IDLE.
- **FSM transitions:**
  - IDLE → RUN when `enable`=1; the first frame starts on that edge.
  - RUN → DRAIN when `enable`=0 and `bit_cnt`≠15.
  - RUN → IDLE when `enable`=0 and `bit_cnt`=15.
  - DRAIN → IDLE at `bit_cnt`=15.
  - A partial frame is never emitted.
- **Frame load:** at every frame start (`bit_cnt`=0 edge):
  - Data slot, FIFO non-empty: pop the FIFO and load the formatted frame.
  - Data slot, FIFO empty: load a zero frame, pulse `underflow`, and still advance `slot_cnt`.
  - Pad slot: load a zero frame; the FIFO is not popped.
- **Simultaneous events:**
  - A push and a pop in the same cycle are both honored, with count unchanged.
  - When the FIFO is full, `tready` drops. A pop in that cycle does not re-raise `tready` until the next cycle.
- **Reset mid-operation:** immediate return to IDLE, FIFO flushed, and all outputs take their reset values on the next edge.

## Timing
- **Reset values:**
  - `iq_data_out`=2'b00, `tx_active`=0, `underflow`=0.
  - `s00_axis_tready`=1 in the cycle after reset release.
- **Registered output:** `iq_data_out` is registered. The frame-start edge drives frame[31:30] and loads the shifter with frame<<2. Each following edge outputs shifter[31:30] and shifts left by 2.
- **Enable latency:** with `enable` sampled high at edge k, `iq_data_out` shows 2'b10 after edge k (bit_cnt 0), and the Q_SYNC 2'b01 appears at bit_cnt 8.
- **Input-to-output latency:** a word accepted at edge k can be loaded no earlier than edge k+1.
- **Throughput:** one sample per 16·N cycles. `underflow` is high for exactly the cycle after the failing frame-start edge.

## Structure
- **Package `at86rf215_pkg`** (shared with the RX block):
  - Constants I_SYNC=2'b10, Q_SYNC=2'b01, FRAME_BITS=32, IQ_BITS=13.
  - Function `iq_frame(i,q)` returning the formatted frame.
  - FSM enum `tx_state_t` {IDLE, RUN, DRAIN}.
- **Sub-module `at86rf215_tx_fifo`:**
  - Synchronous FIFO, `FIFO_DEPTH` × 32 bits, first-word-fall-through.
  - Ports: push/full, pop/empty, `aresetn` flush.
- **Top level:** FSM, counters, frame formatter and shifter.

## Test plan
1. **Single sample, sample_rate=1:** reset, `enable`=1, push I=13'h0123, Q=13'h1FFF → serial stream reassembles to {10,0000100100011,0,01,1111111111111,0}, then an `underflow` pulse at the next frame start and zero frames after it.
2. **Stream with padding, sample_rate=4:** push 30 words with I=Q=k → one data frame followed by 3 zero frames per sample; looped back into `axi_at86rf215_iq_rx`, `in_sync` asserts and it outputs I/Q=k in order.
3. **Backpressure and FIFO full:** hold `enable`=0, push 5 words with `FIFO_DEPTH`=4 → `tready` falls after the 4th acceptance. Raise `enable` → `tready` rises one cycle after the first pop, and there is no loss or duplication.
4. **Enable drop mid-frame:** deassert `enable` at `bit_cnt`=5 → the frame completes through `bit_cnt`=15, then the FSM enters IDLE with `iq_data_out`=0, `tx_active`=0, and the FIFO remains unchanged.
5. **Sample-rate change and clamps:** change `sample_rate` 4→2 during slot 2 → the current period still completes 4 slots, and the next period has 2. `sample_rate`=0 behaves as 1; `sample_rate`=15 behaves as 10.
6. **Reset mid-frame:** drop `aresetn` at `bit_cnt`=7 with 3 words queued → next edge shows `iq_data_out`=0, IDLE state, and an empty FIFO. After release, `tready`=1 and no stale samples are emitted.

Source files
------------

// File: rtl/at86rf215_pkg.sv
// Shared definitions for the AT86RF215 LVDS I/Q serial interface (TX and RX).
// Holds the frame sync headers, field widths, frame formatter and TX FSM states.
package at86rf215_pkg;

    localparam logic [1:0] I_SYNC     = 2'b10;
    localparam logic [1:0] Q_SYNC     = 2'b01;
    localparam int         FRAME_BITS = 32;
    localparam int         IQ_BITS    = 13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } tx_state_t;

    // One 32-bit transceiver frame: sync header, 13-bit sample and a zero pad bit per half.
    function automatic logic [FRAME_BITS-1:0] iq_frame(input logic [IQ_BITS-1:0] i,
                                                       input logic [IQ_BITS-1:0] q);
        return {I_SYNC, i, 1'b0, Q_SYNC, q, 1'b0};
    endfunction

endpackage

// File: rtl/at86rf215_tx_fifo.sv
// First-word-fall-through sample FIFO; o_data always shows the oldest entry.
// A synchronous active-low aresetn flushes the contents.
module at86rf215_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    // Full and empty come from the registered count, so a pop only re-opens space next cycle.
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/axi_at86rf215_iq_tx.sv
// AXI-Stream to AT86RF215 LVDS I/Q serializer: one formatted frame per data slot,
// zero frames in the padding slots, shifted out MSB first two bits per clock.
module axi_at86rf215_iq_tx
    import at86rf215_pkg::*;
#(
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int FIFO_DEPTH             = 4,
    parameter int MAX_SAMPLE_RATE        = 10
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic                              s00_axis_tvalid,
    output logic                              s00_axis_tready,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
    input  logic                              s00_axis_tlast,
    input  logic [3:0]                        sample_rate,
    input  logic                              enable,
    output logic [1:0]                        iq_data_out,
    output logic                              tx_active,
    output logic                              underflow
);

    localparam logic [3:0] MAX_RATE = 4'(MAX_SAMPLE_RATE);

    tx_state_t               r_state;
    logic [3:0]              r_bit_cnt;
    logic [3:0]              r_slot_cnt;
    logic [3:0]              r_n;
    logic [FRAME_BITS-1:0]   r_shift;
    logic [1:0]              r_out;
    logic                    r_underflow;

    logic [3:0]              w_rate;
    logic                    w_last_bit;
    logic                    w_frame_start;
    logic [3:0]              w_next_slot;
    logic                    w_data_slot;
    logic                    w_pop;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic [C_S00_AXIS_TDATA_WIDTH-1:0] w_fifo_data;
    logic [FRAME_BITS-1:0]   w_frame;
    logic                    w_unused;

    at86rf215_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (C_S00_AXIS_TDATA_WIDTH)
    ) u_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .i_push  (s00_axis_tvalid),
        .i_data  (s00_axis_tdata),
        .o_full  (w_fifo_full),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_empty (w_fifo_empty)
    );

    always_comb begin
        if (sample_rate == 4'd0)
            w_rate = 4'd1;
        else if (sample_rate > MAX_RATE)
            w_rate = MAX_RATE;
        else
            w_rate = sample_rate;
    end

    // A new frame starts leaving IDLE or straight after bit 15 while still enabled.
    assign w_last_bit    = (r_bit_cnt == 4'd15);
    assign w_frame_start = enable && ((r_state == IDLE) || ((r_state == RUN) && w_last_bit));
    assign w_next_slot   = ((r_state == IDLE) || (r_slot_cnt == r_n - 4'd1)) ? 4'd0
                                                                              : r_slot_cnt + 4'd1;
    assign w_data_slot   = (w_next_slot == 4'd0);
    assign w_pop         = w_frame_start && w_data_slot && !w_fifo_empty;
    assign w_frame       = (w_data_slot && !w_fifo_empty)
                         ? iq_frame(w_fifo_data[28:16], w_fifo_data[12:0]) : '0;

    assign s00_axis_tready = !w_fifo_full;
    assign iq_data_out     = r_out;
    assign tx_active       = (r_state == RUN);
    assign underflow       = r_underflow;
    assign w_unused        = ^{s00_axis_tlast, w_fifo_data[31:29], w_fifo_data[15:13]};

    // The period length is captured only when slot 0 begins, so rate changes wait a full period.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_slot_cnt  <= '0;
            r_n         <= 4'd1;
            r_shift     <= '0;
            r_out       <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_underflow <= w_frame_start && w_data_slot && w_fifo_empty;
            if (w_frame_start) begin
                r_state    <= RUN;
                r_bit_cnt  <= '0;
                r_slot_cnt <= w_next_slot;
                if (w_data_slot) r_n <= w_rate;
                r_out      <= w_frame[31:30];
                r_shift    <= {w_frame[29:0], 2'b00};
            end else if ((r_state == IDLE) || w_last_bit) begin
                r_state    <= IDLE;
                r_bit_cnt  <= '0;
                r_slot_cnt <= '0;
                r_out      <= '0;
            end else begin
                if (!enable) r_state <= DRAIN;
                r_bit_cnt <= r_bit_cnt + 4'd1;
                r_out     <= r_shift[31:30];
                r_shift   <= {r_shift[29:0], 2'b00};
            end
        end
    end

endmodule

// File: tb/tb_axi_at86rf215_iq_tx.sv
// Self-checking bench for axi_at86rf215_iq_tx: reassembles the serial dibit stream
// into frames and compares them against a sample-period model fed by accepted words.
module tb_axi_at86rf215_iq_tx;

    logic        aclk            = 1'b0;
    logic        aresetn         = 1'b0;
    logic        s00_axis_tvalid = 1'b0;
    logic        s00_axis_tready;
    logic [31:0] s00_axis_tdata  = '0;
    logic        s00_axis_tlast  = 1'b0;
    logic [3:0]  sample_rate     = 4'd1;
    logic        enable          = 1'b0;
    logic [1:0]  iq_data_out;
    logic        tx_active;
    logic        underflow;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] modelQ[$];
    logic [31:0] feedQ[$];
    int          mSlot;
    int          mN;
    logic [31:0] gotFrame [64];
    logic [31:0] expFrame [64];
    logic        gotUf    [64];
    logic        expUf    [64];
    logic        gotActive[1024];
    logic        gotReady [1024];
    int          strayUf;
    logic        pendingValid;
    logic [31:0] pendingWord;

    axi_at86rf215_iq_tx #(
        .C_S00_AXIS_TDATA_WIDTH (32),
        .FIFO_DEPTH             (4),
        .MAX_SAMPLE_RATE        (10)
    ) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .s00_axis_tvalid (s00_axis_tvalid),
        .s00_axis_tready (s00_axis_tready),
        .s00_axis_tdata  (s00_axis_tdata),
        .s00_axis_tlast  (s00_axis_tlast),
        .sample_rate     (sample_rate),
        .enable          (enable),
        .iq_data_out     (iq_data_out),
        .tx_active       (tx_active),
        .underflow       (underflow)
    );

    always #5 aclk = ~aclk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] expectFrame(input logic [31:0] w);
        return (32'd2 << 30) | (32'(w[28:16]) << 17) | (32'd1 << 14) | (32'(w[12:0]) << 1);
    endfunction

    function automatic int effRate(input logic [3:0] r);
        if (r == 4'd0) return 1;
        if (r > 4'd10) return 10;
        return int'(r);
    endfunction

    // Offer one word while idle; gives up after a bounded wait.
    task automatic drive_word(input logic [31:0] w);
        bit accepted;
        accepted = 1'b0;
        s00_axis_tvalid = 1'b1;
        s00_axis_tdata  = w;
        for (int t = 0; t < 50 && !accepted; t++) begin
            if (s00_axis_tready) accepted = 1'b1;
            @(negedge aclk);
        end
        s00_axis_tvalid = 1'b0;
        vectors++;
        if (!accepted) begin
            miscompares++;
            $display("[TB] FAIL drive_word: tready=%0b, required 1 within 50 cycles", s00_axis_tready);
        end else begin
            modelQ.push_back(w);
        end
    endtask

    // Enable the transmitter, capture nFrames frames and build the expected frame list.
    task automatic run_frames(input int nFrames, input int dropAt, input int rateAt,
                              input logic [3:0] newRate);
        int          last;
        int          dropIdx;
        int          f;
        int          b;
        logic [31:0] acc;
        last    = nFrames * 16 - 1;
        dropIdx = (dropAt < 0) ? last : dropAt;
        acc     = '0;
        strayUf = 0;
        mSlot   = 0;
        mN      = 1;
        pendingValid = 1'b0;
        enable  = 1'b1;
        for (int idx = 0; idx <= last; idx++) begin
            f = idx / 16;
            b = idx % 16;
            @(negedge aclk);
            acc = {acc[29:0], iq_data_out};
            gotActive[idx] = tx_active;
            gotReady[idx]  = s00_axis_tready;
            if (b == 0) begin
                gotUf[f] = underflow;
                if (mSlot == 0) begin
                    mN = effRate(sample_rate);
                    if (modelQ.size() > 0) begin
                        expFrame[f] = expectFrame(modelQ.pop_front());
                        expUf[f]    = 1'b0;
                    end else begin
                        expFrame[f] = '0;
                        expUf[f]    = 1'b1;
                    end
                end else begin
                    expFrame[f] = '0;
                    expUf[f]    = 1'b0;
                end
                mSlot = (mSlot + 1 == mN) ? 0 : mSlot + 1;
            end else if (underflow) begin
                strayUf++;
            end
            if (b == 15) gotFrame[f] = acc;
            if (pendingValid) begin
                modelQ.push_back(pendingWord);
                pendingValid    = 1'b0;
                s00_axis_tvalid = 1'b0;
            end
            if (idx < last) begin
                if (!s00_axis_tvalid && feedQ.size() > 0) begin
                    s00_axis_tvalid = 1'b1;
                    s00_axis_tdata  = feedQ.pop_front();
                end
                if (s00_axis_tvalid && s00_axis_tready) begin
                    pendingValid = 1'b1;
                    pendingWord  = s00_axis_tdata;
                end
            end else if (s00_axis_tvalid) begin
                feedQ.push_front(s00_axis_tdata);
                s00_axis_tvalid = 1'b0;
            end
            if (idx == rateAt)  sample_rate = newRate;
            if (idx == dropIdx) enable = 1'b0;
        end
    endtask

    task automatic test_reset();
        vectors += 4;
        if (iq_data_out !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_iq: got %b, expected 00", iq_data_out); end
        if (tx_active !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_active: got %b, expected 0", tx_active); end
        if (underflow !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_underflow: got %b, expected 0", underflow); end
        if (s00_axis_tready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_tready: got %b, expected 1", s00_axis_tready); end
    endtask

    task automatic test_single_sample();
        sample_rate = 4'd1;
        drive_word({3'b101, 13'h0123, 3'b110, 13'h1FFF});
        run_frames(3, -1, -1, 4'd0);
        vectors += 3;
        if (gotFrame[0] !== 32'b10_0000100100011_0_01_1111111111111_0) begin
            miscompares++; $display("[TB] FAIL single_frame: got %h, expected %h", gotFrame[0], 32'b10_0000100100011_0_01_1111111111111_0);
        end
        if (gotActive[0] !== 1'b1) begin miscompares++; $display("[TB] FAIL single_active: got %b, expected 1", gotActive[0]); end
        if (strayUf !== 0) begin miscompares++; $display("[TB] FAIL single_stray_uf: got %0d, expected 0", strayUf); end
        for (int i = 0; i < 3; i++) begin
            vectors += 2;
            if (gotFrame[i] !== expFrame[i]) begin miscompares++; $display("[TB] FAIL single_f%0d: got %h, expected %h", i, gotFrame[i], expFrame[i]); end
            if (gotUf[i] !== expUf[i]) begin miscompares++; $display("[TB] FAIL single_uf%0d: got %b, expected %b", i, gotUf[i], expUf[i]); end
        end
        @(negedge aclk);
        vectors += 2;
        if (iq_data_out !== 2'b00) begin miscompares++; $display("[TB] FAIL single_idle_iq: got %b, expected 00", iq_data_out); end
        if (tx_active !== 1'b0) begin miscompares++; $display("[TB] FAIL single_idle_active: got %b, expected 0", tx_active); end
    endtask

    task automatic test_stream_padding();
        sample_rate = 4'd4;
        for (int i = 0; i < 4; i++) drive_word($urandom());
        for (int i = 0; i < 8; i++) feedQ.push_back($urandom());
        run_frames(48, -1, -1, 4'd0);
        for (int i = 0; i < 48; i++) begin
            vectors += 2;
            if (gotFrame[i] !== expFrame[i]) begin miscompares++; $display("[TB] FAIL stream_f%0d: got %h, expected %h", i, gotFrame[i], expFrame[i]); end
            if (gotUf[i] !== expUf[i]) begin miscompares++; $display("[TB] FAIL stream_uf%0d: got %b, expected %b", i, gotUf[i], expUf[i]); end
        end
        vectors++;
        if (strayUf !== 0) begin miscompares++; $display("[TB] FAIL stream_stray_uf: got %0d, expected 0", strayUf); end
        @(negedge aclk);
    endtask

    task automatic test_backpressure();
        logic [31:0] w4;
        sample_rate = 4'd1;
        for (int i = 0; i < 4; i++) drive_word($urandom());
        vectors++;
        if (s00_axis_tready !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_full: tready got %b, expected 0", s00_axis_tready); end
        w4 = $urandom();
        s00_axis_tvalid = 1'b1;
        s00_axis_tdata  = w4;
        repeat (3) @(negedge aclk);
        vectors++;
        if (s00_axis_tready !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_hold: tready got %b, expected 0", s00_axis_tready); end
        run_frames(5, -1, -1, 4'd0);
        vectors++;
        if (gotReady[0] !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_reopen: tready got %b, expected 1", gotReady[0]); end
        for (int i = 0; i < 5; i++) begin
            vectors += 2;
            if (gotFrame[i] !== expFrame[i]) begin miscompares++; $display("[TB] FAIL bp_f%0d: got %h, expected %h", i, gotFrame[i], expFrame[i]); end
            if (gotUf[i] !== expUf[i]) begin miscompares++; $display("[TB] FAIL bp_uf%0d: got %b, expected %b", i, gotUf[i], expUf[i]); end
        end
        vectors++;
        if (gotFrame[4] !== expectFrame(w4)) begin miscompares++; $display("[TB] FAIL bp_last: got %h, expected %h", gotFrame[4], expectFrame(w4)); end
        @(negedge aclk);
        vectors++;
        if (tx_active !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_idle: tx_active got %b, expected 0", tx_active); end
    endtask

    task automatic test_enable_drop();
        sample_rate = 4'd2;
        drive_word($urandom());
        drive_word($urandom());
        run_frames(1, 5, -1, 4'd0);
        vectors += 4;
        if (gotFrame[0] !== expFrame[0]) begin miscompares++; $display("[TB] FAIL drop_frame: got %h, expected %h", gotFrame[0], expFrame[0]); end
        if (gotActive[5] !== 1'b1) begin miscompares++; $display("[TB] FAIL drop_active5: got %b, expected 1", gotActive[5]); end
        if (gotActive[6] !== 1'b0) begin miscompares++; $display("[TB] FAIL drop_drain6: got %b, expected 0", gotActive[6]); end
        if (gotActive[15] !== 1'b0) begin miscompares++; $display("[TB] FAIL drop_drain15: got %b, expected 0", gotActive[15]); end
        @(negedge aclk);
        vectors += 2;
        if (iq_data_out !== 2'b00) begin miscompares++; $display("[TB] FAIL drop_idle_iq: got %b, expected 00", iq_data_out); end
        if (tx_active !== 1'b0) begin miscompares++; $display("[TB] FAIL drop_idle_active: got %b, expected 0", tx_active); end
        run_frames(2, -1, -1, 4'd0);
        for (int i = 0; i < 2; i++) begin
            vectors += 2;
            if (gotFrame[i] !== expFrame[i]) begin miscompares++; $display("[TB] FAIL drop_resume_f%0d: got %h, expected %h", i, gotFrame[i], expFrame[i]); end
            if (gotUf[i] !== expUf[i]) begin miscompares++; $display("[TB] FAIL drop_resume_uf%0d: got %b, expected %b", i, gotUf[i], expUf[i]); end
        end
        @(negedge aclk);
    endtask

    task automatic test_rate_change();
        sample_rate = 4'd4;
        drive_word($urandom());
        drive_word($urandom());
        run_frames(7, -1, 2 * 16 + 3, 4'd2);
        for (int i = 0; i < 7; i++) begin
            vectors += 2;
            if (gotFrame[i] !== expFrame[i]) begin miscompares++; $display("[TB] FAIL rate_f%0d: got %h, expected %h", i, gotFrame[i], expFrame[i]); end
            if (gotUf[i] !== expUf[i]) begin miscompares++; $display("[TB] FAIL rate_uf%0d: got %b, expected %b", i, gotUf[i], expUf[i]); end
        end
        vectors++;
        if (strayUf !== 0) begin miscompares++; $display("[TB] FAIL rate_stray_uf: got %0d, expected 0", strayUf); end
        @(negedge aclk);
    endtask

    task automatic test_rate_clamps();
        sample_rate = 4'd0;
        drive_word($urandom());
        drive_word($urandom());
        run_frames(3, -1, -1, 4'd0);
        for (int i = 0; i < 3; i++) begin
            vectors += 2;
            if (gotFrame[i] !== expFrame[i]) begin miscompares++; $display("[TB] FAIL clamp0_f%0d: got %h, expected %h", i, gotFrame[i], expFrame[i]); end
            if (gotUf[i] !== expUf[i]) begin miscompares++; $display("[TB] FAIL clamp0_uf%0d: got %b, expected %b", i, gotUf[i], expUf[i]); end
        end
        @(negedge aclk);
        sample_rate = 4'd15;
        drive_word($urandom());
        run_frames(11, -1, -1, 4'd0);
        for (int i = 0; i < 11; i++) begin
            vectors += 2;
            if (gotFrame[i] !== expFrame[i]) begin miscompares++; $display("[TB] FAIL clamp15_f%0d: got %h, expected %h", i, gotFrame[i], expFrame[i]); end
            if (gotUf[i] !== expUf[i]) begin miscompares++; $display("[TB] FAIL clamp15_uf%0d: got %b, expected %b", i, gotUf[i], expUf[i]); end
        end
        vectors++;
        if (strayUf !== 0) begin miscompares++; $display("[TB] FAIL clamp15_stray_uf: got %0d, expected 0", strayUf); end
        @(negedge aclk);
    endtask

    task automatic test_reset_mid();
        sample_rate = 4'd1;
        for (int i = 0; i < 3; i++) drive_word($urandom());
        enable = 1'b1;
        repeat (8) @(negedge aclk);
        aresetn = 1'b0;
        @(negedge aclk);
        vectors += 4;
        if (iq_data_out !== 2'b00) begin miscompares++; $display("[TB] FAIL rstmid_iq: got %b, expected 00", iq_data_out); end
        if (tx_active !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_active: got %b, expected 0", tx_active); end
        if (underflow !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_underflow: got %b, expected 0", underflow); end
        if (s00_axis_tready !== 1'b1) begin miscompares++; $display("[TB] FAIL rstmid_flush: tready got %b, expected 1", s00_axis_tready); end
        aresetn = 1'b1;
        enable  = 1'b0;
        modelQ.delete();
        @(negedge aclk);
        vectors += 2;
        if (s00_axis_tready !== 1'b1) begin miscompares++; $display("[TB] FAIL rstmid_tready: got %b, expected 1", s00_axis_tready); end
        if (iq_data_out !== 2'b00) begin miscompares++; $display("[TB] FAIL rstmid_idle_iq: got %b, expected 00", iq_data_out); end
        run_frames(2, -1, -1, 4'd0);
        for (int i = 0; i < 2; i++) begin
            vectors += 2;
            if (gotFrame[i] !== expFrame[i]) begin miscompares++; $display("[TB] FAIL rstmid_f%0d: got %h, expected %h", i, gotFrame[i], expFrame[i]); end
            if (gotUf[i] !== expUf[i]) begin miscompares++; $display("[TB] FAIL rstmid_uf%0d: got %b, expected %b", i, gotUf[i], expUf[i]); end
        end
        @(negedge aclk);
    endtask

    initial begin
        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        test_reset();
        test_single_sample();
        test_stream_padding();
        test_backpressure();
        test_enable_drop();
        test_rate_change();
        test_rate_clamps();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
